ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 123 ++++++++++++
 tb/tb_ex_mem_reg.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ex_mem_reg                                                 |
// | Description : EX/MEM pipeline register with valid/ready handshake.       |
// |               Define EX_MEM_SKID_EN for a registered in_ready backed by   |
// |               a skid entry; otherwise a single entry, combinational ready.|
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ex_mem_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu_result,
  input  logic        in_zero,
  input  logic [31:0] in_write_data,
  input  logic [4:0]  in_write_reg,
  input  logic [4:0]  in_ctrl,
  input  logic [31:0] in_branch_target,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu_result,
  output logic        out_zero,
  output logic [31:0] out_write_data,
  output logic [4:0]  out_write_reg,
  output logic [4:0]  out_ctrl,
  output logic [31:0] out_branch_target,
  output logic        out_pc_src
);

  localparam int unsigned c_PAY_W    = 107;
  localparam logic [1:0]  c_ST_EMPTY = 2'd0;
  localparam logic [1:0]  c_ST_ONE   = 2'd1;

  logic [1:0]         r_state;
  logic [c_PAY_W-1:0] r_main;
  logic [c_PAY_W-1:0] w_in_pay;
  logic               w_push;
  logic               w_pop;

  assign w_in_pay = {in_alu_result, in_zero, in_write_data, in_write_reg,
                     in_ctrl, in_branch_target};
  assign w_push   = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

  assign out_valid = (r_state != c_ST_EMPTY);

`ifdef EX_MEM_SKID_EN
  localparam logic [1:0] c_ST_TWO = 2'd2;

  logic [c_PAY_W-1:0] r_skid;
  logic [1:0]         w_state_nxt;
  logic               r_in_ready;

  assign in_ready = r_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_EMPTY: if (w_push) w_state_nxt = c_ST_ONE;
      c_ST_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = c_ST_TWO;
        else if (!w_push && w_pop) w_state_nxt = c_ST_EMPTY;
      end
      c_ST_TWO:   if (w_pop) w_state_nxt = c_ST_ONE;
      default:    w_state_nxt = c_ST_EMPTY;
    endcase
  end

  // Ready is precomputed from the next state so out_ready never reaches in_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_state    <= c_ST_EMPTY;
      r_main     <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != c_ST_TWO);
      case (r_state)
        c_ST_EMPTY: if (w_push) r_main <= w_in_pay;
        c_ST_ONE: begin
          if (w_push && w_pop) r_main <= w_in_pay;
          else if (w_push)     r_skid <= w_in_pay;
        end
        c_ST_TWO:   if (w_pop) r_main <= r_skid;
        default: ;
      endcase
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_ST_EMPTY;
      r_main  <= '0;
    end else if (flush) begin
      r_state <= c_ST_EMPTY;
      r_main  <= '0;
    end else if (w_push) begin
      r_state <= c_ST_ONE;
      r_main  <= w_in_pay;
    end else if (w_pop) begin
      r_state <= c_ST_EMPTY;
    end
  end
`endif

  assign {out_alu_result, out_zero, out_write_data, out_write_reg,
          out_ctrl, out_branch_target} = r_main;

  // ctrl[0] is the branch bit.
  assign out_pc_src = out_valid && out_ctrl[0] && out_zero;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
`default_nettype none
// Testbench for ex_mem_reg: directed vector table, hand sequences and a
// randomized run compared against a queue-based reference model.
module tb_ex_mem_reg;

`ifdef EX_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [4:0]  ctrl;
    logic [31:0] bt;
  } pay_t;

  typedef struct {
    bit          iv;
    bit          ordy;
    logic [31:0] alu;
    bit          e_ov;
    bit          e_ir;
    logic [31:0] e_alu;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  pay_t        d_pay;
  logic [31:0] out_alu_result;
  logic        out_zero;
  logic [31:0] out_write_data;
  logic [4:0]  out_write_reg;
  logic [4:0]  out_ctrl;
  logic [31:0] out_branch_target;
  logic        out_pc_src;
  pay_t        dut_pay;

  int checks = 0;
  int errors = 0;

  pay_t        q[$];
  bit          zeroed;
  bit          last_push;
  logic [31:0] delivered[$];
  vec_t        tbl[6];

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_alu_result    (d_pay.alu),
    .in_zero          (d_pay.zero),
    .in_write_data    (d_pay.wd),
    .in_write_reg     (d_pay.wr),
    .in_ctrl          (d_pay.ctrl),
    .in_branch_target (d_pay.bt),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_alu_result   (out_alu_result),
    .out_zero         (out_zero),
    .out_write_data   (out_write_data),
    .out_write_reg    (out_write_reg),
    .out_ctrl         (out_ctrl),
    .out_branch_target(out_branch_target),
    .out_pc_src       (out_pc_src)
  );

  assign dut_pay = {out_alu_result, out_zero, out_write_data, out_write_reg,
                    out_ctrl, out_branch_target};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: starts just after a falling edge with inputs applied, checks
  // outputs against the model, advances the model at the rising edge.
  task automatic cycle();
    bit   exp_ir;
    bit   push;
    bit   pop;
    pay_t head;
    #1;
    exp_ir = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("payload", dut_pay, q[0]);
      chk("pc_src", out_pc_src, q[0].ctrl[0] & q[0].zero);
    end else begin
      chk("pc_src_idle", out_pc_src, 1'b0);
      if (zeroed) chk("payload_zero", dut_pay, '0);
    end
    push = in_valid && exp_ir;
    pop  = (q.size() != 0) && out_ready;
    @(posedge clk);
    last_push = 1'b0;
    if (flush) begin
      q.delete();
      zeroed = 1'b1;
    end else begin
      if (pop) begin
        head = q.pop_front();
        delivered.push_back(head.alu);
      end
      if (push) q.push_back(d_pay);
      if (push || pop) zeroed = 1'b0;
      last_push = push;
    end
    @(negedge clk);
  endtask

  task automatic set_alu(input logic [31:0] v);
    d_pay      = '0;
    d_pay.alu  = v;
    d_pay.wd   = ~v;
    d_pay.wr   = v[4:0];
    d_pay.ctrl = 5'b10010;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_payload", dut_pay, '0);
    chk("rst_pc_src", out_pc_src, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    zeroed = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    d_pay = '0;
    do_reset();

    // Back-to-back stream with the MEM stage always ready.
    tbl[0] = '{1, 1, 32'h10, 0, 1, 32'h0};
    tbl[1] = '{1, 1, 32'h20, 1, 1, 32'h10};
    tbl[2] = '{1, 1, 32'h30, 1, 1, 32'h20};
    tbl[3] = '{1, 1, 32'h40, 1, 1, 32'h30};
    tbl[4] = '{0, 1, 32'h0,  1, 1, 32'h40};
    tbl[5] = '{0, 1, 32'h0,  0, 1, 32'h0};
    for (int i = 0; i < 6; i++) begin
      set_alu(tbl[i].alu);
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      #1;
      chk("tbl_out_valid", out_valid, tbl[i].e_ov);
      chk("tbl_in_ready", in_ready, tbl[i].e_ir);
      if (tbl[i].e_ov) chk("tbl_alu", out_alu_result, tbl[i].e_alu);
      cycle();
    end

    // Backpressure: A then B with MEM stalled, then released.
    delivered.delete();
    set_alu(32'hA); in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    set_alu(32'hB);
    #1 chk("bp_hold_a", out_alu_result, 32'hA);
`ifdef EX_MEM_SKID_EN
    cycle();
    in_valid = 1'b0;
    #1;
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_hold_a2", out_alu_result, 32'hA);
    cycle();
`else
    chk("bp_in_ready_low", in_ready, 1'b0);
    cycle();
    #1 chk("bp_hold_a2", out_alu_result, 32'hA);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 4 && in_valid; k++) begin
      cycle();
      if (last_push) in_valid = 1'b0;
    end
    repeat (3) cycle();
    chk("bp_count", delivered.size(), 2);
    if (delivered.size() == 2) begin
      chk("bp_first", delivered[0], 32'hA);
      chk("bp_second", delivered[1], 32'hB);
    end
    #1 chk("bp_in_ready_back", in_ready, 1'b1);
    cycle();

    // Branch resolution with zero set and clear.
    out_ready = 1'b1;
    d_pay = '0; d_pay.zero = 1'b1; d_pay.ctrl = 5'b00001; d_pay.bt = 32'h0040_0020;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    #1;
    chk("br_taken", out_pc_src, 1'b1);
    chk("br_target", out_branch_target, 32'h0040_0020);
    cycle();
    d_pay.zero = 1'b0;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    #1;
    chk("br_not_taken", out_pc_src, 1'b0);
    chk("br_target2", out_branch_target, 32'h0040_0020);
    cycle();

    // Flush while full, with a simultaneous valid input.
    delivered.delete();
    out_ready = 1'b0;
    set_alu(32'h111); in_valid = 1'b1;
    cycle();
    if (SKID) begin
      set_alu(32'h222);
      cycle();
    end
    set_alu(32'h333); flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_payload", dut_pay, '0);
    chk("fl_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("fl_nothing_out", delivered.size(), 0);

    // Asynchronous reset in the middle of a cycle with one entry held.
    out_ready = 1'b0;
    set_alu(32'h55); d_pay.zero = 1'b1; d_pay.ctrl = 5'b00001; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_payload", dut_pay, '0);
    chk("ar_pc_src", out_pc_src, 1'b0);
    chk("ar_in_ready", in_ready, 1'b1);
    q.delete();
    zeroed = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cycle();

`ifndef EX_MEM_SKID_EN
    // Combinational ready follows out_ready within the cycle.
    set_alu(32'h77); in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    #1 chk("cr_low", in_ready, 1'b0);
    out_ready = 1'b1;
    #1 chk("cr_high", in_ready, 1'b1);
    out_ready = 1'b0;
    #1 chk("cr_low2", in_ready, 1'b0);
    out_ready = 1'b1;
    cycle();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      in_valid   = $urandom_range(0, 1);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      d_pay.alu  = $urandom;
      d_pay.zero = $urandom_range(0, 1);
      d_pay.wd   = $urandom;
      d_pay.wr   = 5'($urandom);
      d_pay.ctrl = 5'($urandom);
      d_pay.bt   = $urandom;
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
